// File: rtl/rc_sampler.sv
// Rejection-samples 17-bit field elements mod Q from a stream of XOF words and
// packs S accepted elements per output vector, handed off over valid/ready.
module rc_sampler #(
  parameter int unsigned BITLEN = 17,
  parameter int unsigned Q      = 65537,
  parameter int unsigned S      = 32,
  parameter int unsigned XW     = 64
) (
  input  logic                  clk,
  input  logic                  rst_rcg,
  input  logic                  start,
  input  logic [7:0]            nvec,
  input  logic                  nz_req,
  input  logic [XW-1:0]         xof_word,
  input  logic                  xof_valid,
  output logic                  xof_ready,
  output logic [BITLEN*S-1:0]   rc_vec,
  output logic                  rc_valid,
  input  logic                  rc_ready,
  output logic                  busy,
  output logic                  done_rcg
);

  localparam int unsigned EW = $clog2(S);
  localparam int unsigned VW = BITLEN * S;

  typedef enum logic [1:0] {IDLE, FILL, HOLD, DRAIN} state_t;

  state_t            state, state_d;
  logic [EW-1:0]     elem_cnt;
  logic [7:0]        vec_cnt;
  logic [7:0]        nvec_lat;
  logic              nz_lat;
  logic [VW-1:0]     fill;

  logic [BITLEN-1:0] cand_c;
  logic              accept_c;
  logic              out_free_c;
  logic              last_c;
  logic              job_start_c;
  logic              fill_wr_c;
  logic              elem_inc_c;
  logic              elem_clr_c;
  logic              vec_inc_c;
  logic              load_cand_c;
  logic              load_fill_c;
  logic              done_d_c;
  logic              unused_hi_c;

  // Only the low BITLEN bits of each XOF word form the candidate.
  assign cand_c      = xof_word[BITLEN-1:0];
  assign unused_hi_c = ^xof_word[XW-1:BITLEN];
  assign accept_c    = (32'(cand_c) < Q) && !(nz_lat && (cand_c == '0));
  assign out_free_c  = !rc_valid || rc_ready;
  assign last_c      = (vec_cnt + 8'd1) == nvec_lat;

  // Next-state and datapath control.
  always_comb begin
    state_d     = state;
    job_start_c = 1'b0;
    fill_wr_c   = 1'b0;
    elem_inc_c  = 1'b0;
    elem_clr_c  = 1'b0;
    vec_inc_c   = 1'b0;
    load_cand_c = 1'b0;
    load_fill_c = 1'b0;
    done_d_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (nvec != 8'd0) begin
            job_start_c = 1'b1;
            state_d     = FILL;
          end else begin
            done_d_c = 1'b1;
          end
        end
      end
      FILL: begin
        if (xof_valid && xof_ready && accept_c) begin
          if (elem_cnt == EW'(S - 1)) begin
            if (out_free_c) begin
              load_cand_c = 1'b1;
              elem_clr_c  = 1'b1;
              vec_inc_c   = 1'b1;
              state_d     = last_c ? DRAIN : FILL;
            end else begin
              // Park the completed vector until the consumer frees the output.
              fill_wr_c = 1'b1;
              state_d   = HOLD;
            end
          end else begin
            fill_wr_c  = 1'b1;
            elem_inc_c = 1'b1;
          end
        end
      end
      HOLD: begin
        if (rc_ready) begin
          load_fill_c = 1'b1;
          elem_clr_c  = 1'b1;
          vec_inc_c   = 1'b1;
          state_d     = last_c ? DRAIN : FILL;
        end
      end
      DRAIN: begin
        if (rc_valid && rc_ready) begin
          done_d_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_rcg) begin
      state     <= IDLE;
      elem_cnt  <= '0;
      vec_cnt   <= '0;
      nvec_lat  <= '0;
      nz_lat    <= 1'b0;
      fill      <= '0;
      rc_vec    <= '0;
      rc_valid  <= 1'b0;
      xof_ready <= 1'b0;
      busy      <= 1'b0;
      done_rcg  <= 1'b0;
    end else begin
      state     <= state_d;
      xof_ready <= (state_d == FILL);
      busy      <= (state_d != IDLE);
      done_rcg  <= done_d_c;

      if (job_start_c) begin
        nvec_lat <= nvec;
        nz_lat   <= nz_req;
        elem_cnt <= '0;
        vec_cnt  <= '0;
      end else begin
        if (elem_clr_c) begin
          elem_cnt <= '0;
        end else if (elem_inc_c) begin
          elem_cnt <= elem_cnt + EW'(1);
        end
        if (vec_inc_c) begin
          vec_cnt <= vec_cnt + 8'd1;
        end
      end

      for (int i = 0; i < S; i++) begin
        if (fill_wr_c && (elem_cnt == EW'(i))) begin
          fill[i*BITLEN +: BITLEN] <= cand_c;
        end
      end

      // A same-cycle load keeps rc_valid high across the handshake.
      if (load_cand_c) begin
        rc_vec   <= {cand_c, fill[VW-BITLEN-1:0]};
        rc_valid <= 1'b1;
      end else if (load_fill_c) begin
        rc_vec   <= fill;
        rc_valid <= 1'b1;
      end else if (rc_valid && rc_ready) begin
        rc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rc_sampler.sv
// Directed bench for rc_sampler: expected vectors and done pulses are queued at
// stimulus time and retired by a monitor on each output handshake.
module tb_rc_sampler;

  localparam int unsigned BITLEN = 17;
  localparam int unsigned S      = 32;
  localparam int unsigned XW     = 64;
  localparam int unsigned VW     = BITLEN * S;

  logic           clk = 1'b0;
  logic           rst_rcg = 1'b1;
  logic           start = 1'b0;
  logic [7:0]     nvec = '0;
  logic           nz_req = 1'b0;
  logic [XW-1:0]  xof_word = '0;
  logic           xof_valid = 1'b0;
  logic           xof_ready;
  logic [VW-1:0]  rc_vec;
  logic           rc_valid;
  logic           rc_ready = 1'b0;
  logic           busy;
  logic           done_rcg;

  int total = 0;
  int bad   = 0;
  logic [VW-1:0] exp_q[$];
  int exp_done = 0;

  rc_sampler #(.BITLEN(17), .Q(65537), .S(32), .XW(64)) dut (
    .clk(clk), .rst_rcg(rst_rcg), .start(start), .nvec(nvec), .nz_req(nz_req),
    .xof_word(xof_word), .xof_valid(xof_valid), .xof_ready(xof_ready),
    .rc_vec(rc_vec), .rc_valid(rc_valid), .rc_ready(rc_ready),
    .busy(busy), .done_rcg(done_rcg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: retire expected vectors and done pulses as the DUT presents them.
  always @(negedge clk) begin
    if (rst_rcg === 1'b0) begin
      if (rc_valid && rc_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_vec: got %0h want none", rc_vec);
        end else begin
          chk("vec", rc_vec, exp_q.pop_front());
        end
      end
      if (done_rcg) begin
        total++;
        if (exp_done == 0) begin
          bad++;
          $display("FAIL unexpected_done: got 1 want 0");
        end else begin
          exp_done--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] n, input logic nz);
    start = 1'b1; nvec = n; nz_req = nz;
    tick();
    start = 1'b0; nvec = $urandom_range(0, 255); nz_req = 1'(($urandom & 1));
  endtask

  task automatic send_word(input logic [XW-1:0] w);
    int n = 0;
    xof_word = w; xof_valid = 1'b1;
    @(negedge clk);
    while (!xof_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!xof_ready) begin
      total++; bad++;
      $display("FAIL xof_timeout: got xof_ready=0 want 1");
    end
    tick();
    xof_valid = 1'b0;
  endtask

  logic [VW-1:0] v, v0, v1;

  initial begin
    // Reset with random inputs.
    for (int c = 0; c < 3; c++) begin
      start = 1'(($urandom & 1)); nvec = 8'($urandom); nz_req = 1'(($urandom & 1));
      xof_word = {$urandom, $urandom}; xof_valid = 1'(($urandom & 1));
      rc_ready = 1'(($urandom & 1));
      tick();
    end
    chk("rst_rc_vec", rc_vec, '0);
    chk("rst_rc_valid", VW'(rc_valid), '0);
    chk("rst_xof_ready", VW'(xof_ready), '0);
    chk("rst_busy", VW'(busy), '0);
    chk("rst_done", VW'(done_rcg), '0);
    rst_rcg = 1'b0; start = 1'b0; xof_valid = 1'b0; rc_ready = 1'b1;
    tick();

    // Basic job: elements 0..31, upper word bits are noise.
    v = '0;
    for (int i = 0; i < 32; i++) v[i*BITLEN +: BITLEN] = 17'(i);
    exp_q.push_back(v); exp_done++;
    start_job(8'd1, 1'b0);
    chk("basic_busy", VW'(busy), VW'(1));
    chk("basic_xof_ready", VW'(xof_ready), VW'(1));
    for (int i = 0; i < 32; i++) send_word({32'hDEADBEEF, 15'h5A5A, 17'(i)});
    chk("basic_valid_lat", VW'(rc_valid), VW'(1));
    chk("basic_vec", rc_vec, v);
    tick();
    chk("basic_done", VW'(done_rcg), VW'(1));
    chk("basic_busy_off", VW'(busy), '0);
    chk("basic_valid_off", VW'(rc_valid), '0);
    tick();
    chk("basic_done_pulse", VW'(done_rcg), '0);

    // Rejection: 65537 and 131071 dropped, 65536 lands in slot 5.
    v = '0;
    for (int i = 0; i < 32; i++)
      v[i*BITLEN +: BITLEN] = (i < 5) ? 17'(100 + i) : (i == 5) ? 17'(65536) : 17'(200 + i);
    exp_q.push_back(v); exp_done++;
    start_job(8'd1, 1'b0);
    for (int i = 0; i < 5; i++) send_word(64'(100 + i));
    send_word(64'h1234_5678_0001_0001);
    send_word(64'h0000_0000_0001_FFFF);
    chk("rej_no_output", VW'(rc_valid), '0);
    send_word(64'hDEAD_BEEF_0001_0000);
    for (int i = 6; i < 32; i++) send_word(64'(200 + i));
    chk("rej_vec", rc_vec, v);
    tick();
    chk("rej_done", VW'(done_rcg), VW'(1));
    tick();

    // Nonzero mode: zero candidates rejected.
    v = '0;
    for (int i = 0; i < 32; i++) v[i*BITLEN +: BITLEN] = 17'(i + 1);
    exp_q.push_back(v); exp_done++;
    start_job(8'd1, 1'b1);
    send_word(64'h0);
    for (int i = 0; i < 32; i++) begin
      if (i == 10) send_word(64'hFFFF_FFFF_FFFE_0000);
      send_word(64'(i + 1));
    end
    chk("nz_vec", rc_vec, v);
    tick();
    chk("nz_done", VW'(done_rcg), VW'(1));
    tick();

    // Same zero word accepted without nonzero mode.
    v = '0;
    for (int i = 1; i < 32; i++) v[i*BITLEN +: BITLEN] = 17'(i * 1000);
    exp_q.push_back(v); exp_done++;
    start_job(8'd1, 1'b0);
    send_word(64'hFFFF_FFFF_FFFE_0000);
    for (int i = 1; i < 32; i++) send_word(64'(i * 1000));
    chk("z_vec", rc_vec, v);
    tick();
    chk("z_done", VW'(done_rcg), VW'(1));
    tick();

    // Backpressure: two vectors with the consumer stalled.
    v0 = '0; v1 = '0;
    for (int i = 0; i < 32; i++) begin
      v0[i*BITLEN +: BITLEN] = 17'(300 + i);
      v1[i*BITLEN +: BITLEN] = 17'(60000 + i);
    end
    exp_q.push_back(v0); exp_q.push_back(v1); exp_done++;
    rc_ready = 1'b0;
    start_job(8'd2, 1'b0);
    for (int i = 0; i < 32; i++) send_word(64'(300 + i));
    chk("bp_v0_valid", VW'(rc_valid), VW'(1));
    chk("bp_fill_ready", VW'(xof_ready), VW'(1));
    for (int i = 0; i < 32; i++) send_word({47'h1, 17'(60000 + i)});
    chk("bp_hold_ready", VW'(xof_ready), '0);
    chk("bp_hold_vec", rc_vec, v0);
    start = 1'b1; nvec = 8'd5;
    tick();
    start = 1'b0;
    tick();
    chk("bp_hold_stable", rc_vec, v0);
    chk("bp_hold_valid", VW'(rc_valid), VW'(1));
    chk("bp_busy", VW'(busy), VW'(1));
    rc_ready = 1'b1;
    tick();
    rc_ready = 1'b0;
    chk("bp_v1_vec", rc_vec, v1);
    chk("bp_v1_valid", VW'(rc_valid), VW'(1));
    chk("bp_no_early_done", VW'(done_rcg), '0);
    tick();
    rc_ready = 1'b1;
    tick();
    chk("bp_done", VW'(done_rcg), VW'(1));
    chk("bp_valid_off", VW'(rc_valid), '0);
    tick();

    // Abort mid-fill, then a zero-length job.
    start_job(8'd1, 1'b0);
    for (int i = 0; i < 10; i++) send_word(64'(i + 7));
    rst_rcg = 1'b1;
    tick();
    rst_rcg = 1'b0;
    chk("abort_vec", rc_vec, '0);
    chk("abort_valid", VW'(rc_valid), '0);
    chk("abort_ready", VW'(xof_ready), '0);
    chk("abort_busy", VW'(busy), '0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_no_done", VW'(done_rcg), '0);
    end
    exp_done++;
    start_job(8'd0, 1'b0);
    chk("zero_done", VW'(done_rcg), VW'(1));
    chk("zero_busy", VW'(busy), '0);
    chk("zero_valid", VW'(rc_valid), '0);
    tick();
    chk("zero_done_pulse", VW'(done_rcg), '0);
    chk("zero_valid_after", VW'(rc_valid), '0);
    tick();

    chk("vec_queue_empty", VW'(exp_q.size()), '0);
    chk("done_all_seen", VW'(exp_done), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/rc_sampler.md
Name: rc_sampler

Overview:
- Producer side of the round-constant path.
- Consumes a stream of 64-bit XOF (SHAKE128) words and rejection-samples field elements mod q = 65537.
- Packs S = 32 accepted elements into one BITLEN*S-bit vector and hands it over with a valid/ready handshake.
- Its output drives the in_rc input of the round-constant adder stage; it is also reused for matrix-row generation (nonzero sampling).

Parameters:
BITLEN, 17, element width in bits
Q, 65537, prime modulus; candidates >= Q are rejected
S, 32, elements per output vector
XW, 64, XOF input word width

Ports:
clk  in  1  single clock, all logic on rising edge
rst_rcg  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins a job; ignored unless idle
nvec  in  8  number of vectors to produce for this job; latched on start
nz_req  in  1  1 = also reject 0 (nonzero sampling); latched on start
xof_word  in  XW  XOF output word
xof_valid  in  1  xof_word valid
xof_ready  out  1  sampler accepts xof_word this cycle
rc_vec  out  BITLEN*S  packed vector; element i at bits [BITLEN*i +: BITLEN]
rc_valid  out  1  rc_vec valid
rc_ready  in  1  consumer takes rc_vec
busy  out  1  high whenever state != IDLE
done_rcg  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset (rst_rcg=1 at a clock edge):
  - State IDLE; elem_cnt, vec_cnt and fill buffer cleared.
  - rc_vec=0, rc_valid=0, xof_ready=0, busy=0, done_rcg=0.
  - Reset mid-job abandons any partial or held vector. No done_rcg is issued.
- Word transfer occurs when xof_valid && xof_ready.
  - cand = xof_word[BITLEN-1:0]; bits above BITLEN are ignored.
  - Accept iff cand < Q and !(nz_lat && cand == 0). 65536 is accepted; 65537..131071 are rejected.
  - A rejected word is consumed and discarded; counters are unchanged.
- Accepted element is written to fill slot elem_cnt; elem_cnt increments (0..S-1).
- Output register: while rc_valid && !rc_ready, rc_vec and rc_valid hold stable. A handshake clears rc_valid unless a new vector loads in the same cycle.
- States:
  - IDLE: xof_ready=0.
    - start && nvec != 0: latch nvec and nz_req, clear counters, go to FILL.
    - start && nvec == 0: done_rcg pulses on the next cycle; stay IDLE.
  - FILL: xof_ready=1.
    - On acceptance into slot S-1, if the output is free (!rc_valid || rc_ready): load rc_vec from fill buffer plus the current candidate; rc_valid=1 on the next cycle; elem_cnt=0; vec_cnt++.
    - Then go to DRAIN if vec_cnt reached nvec, else stay in FILL.
    - If the output is not free on that acceptance, go to HOLD.
    - Latency: 32nd accepted word to rc_valid is 1 cycle when the output is free.
  - HOLD: xof_ready=0; full fill buffer retained.
    - On rc_ready: load the fill buffer into rc_vec in the same edge (rc_valid stays 1); elem_cnt=0; vec_cnt++.
    - Then go to DRAIN if last, else FILL.
  - DRAIN: xof_ready=0.
    - On rc_valid && rc_ready: rc_valid=0, done_rcg=1 for one cycle, go to IDLE.
- start while busy: ignored; latched values are unchanged.
- busy=1 in FILL/HOLD/DRAIN; busy drops in the same cycle done_rcg asserts.
- Counters: vec_cnt and nvec are 8-bit; at most 255 vectors per job, no wrap.

Test Plan:
- Reset check: hold rst_rcg=1 for 3 cycles with random inputs -> rc_vec=0, rc_valid=0, xof_ready=0, busy=0, done_rcg=0.
- Basic job: start, nvec=1, nz_req=0; feed words with low bits 0..31 back-to-back; rc_ready=1 -> rc_valid high 1 cycle after the 32nd word, element i == i. done_rcg pulses the cycle after the handshake; busy then 0.
- Rejection: insert words 0x...1_0001 (65537), 0x...1_FFFF, 0xDEADBEEF_0001_0000 -> first two consumed with no slot advance; third accepted as 65536 in the next slot.
- Nonzero mode: nz_req=1 with word 0x0 -> rejected, elem_cnt unchanged. Same word with nz_req=0 -> accepted as 0.
- Backpressure: nvec=2, rc_ready=0; feed 64 accepted words -> after vec0 presents and vec1 fills, xof_ready=0 and rc_vec holds vec0. Raise rc_ready 1 cycle -> vec1 on rc_vec next cycle, rc_valid stays 1. Second handshake -> done_rcg.
- Abort and zero job: reset after 10 accepts -> all outputs cleared, no done_rcg. Then start with nvec=0 -> done_rcg pulse next cycle, rc_valid never asserts.
